// File: rtl/player_life_ctrl.sv
// ---------------------------------------------------------------------------
// player_life_ctrl
// Player sprite sequencing: tracks remaining lives, runs the post-hit blink
// window (hits masked, sprite toggling on each tick edge) and flags game over.
//
// Parameters:
//   LIVES        lives loaded at game start (1..7)
//   BLINK_TICKS  tick edges spent blinking after a non-fatal hit (2..15)
//
// Ports:
//   clk           system clock
//   resetN        asynchronous active-low reset
//   playGame      level; low forces IDLE on the next clock, overrides all
//   startGame     single-cycle pulse; starts/restarts a game
//   tick          slow timebase level; rising edges advance the blink window
//   playerHit     collision report, sampled every cycle
//   visible       sprite may be drawn
//   invulnerable  hits are currently masked
//   lives         remaining lives
//   lifeLost      one-cycle pulse per accepted hit
//   gameOver      high while in OVER
// ---------------------------------------------------------------------------
module player_life_ctrl #(
    parameter int LIVES       = 3,
    parameter int BLINK_TICKS = 8
) (
    input  logic       clk,
    input  logic       resetN,
    input  logic       playGame,
    input  logic       startGame,
    input  logic       tick,
    input  logic       playerHit,
    output logic       visible,
    output logic       invulnerable,
    output logic [2:0] lives,
    output logic       lifeLost,
    output logic       gameOver
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ALIVE = 2'd1,
        S_BLINK = 2'd2,
        S_OVER  = 2'd3
    } state_t;

    state_t     r_state;
    state_t     w_state_nxt;
    logic [2:0] r_lives;
    logic [2:0] w_lives_nxt;
    logic [3:0] r_blink_cnt;
    logic [3:0] w_blink_cnt_nxt;
    logic       r_life_lost;
    logic       w_life_lost_nxt;
    logic       r_tick_q;
    logic       w_tick_edge;

    // A tick level held for many cycles produces a single edge.
    assign w_tick_edge = tick & ~r_tick_q;

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            r_tick_q <= 1'b0;
        end else if (!playGame) begin
            r_tick_q <= 1'b0;
        end else begin
            r_tick_q <= tick;
        end
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            r_state     <= S_IDLE;
            r_lives     <= 3'd0;
            r_blink_cnt <= 4'd0;
            r_life_lost <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_lives     <= w_lives_nxt;
            r_blink_cnt <= w_blink_cnt_nxt;
            r_life_lost <= w_life_lost_nxt;
        end
    end

    // Priority: playGame low, then startGame, then an accepted hit, then tick.
    always_comb begin
        w_state_nxt     = r_state;
        w_lives_nxt     = r_lives;
        w_blink_cnt_nxt = r_blink_cnt;
        w_life_lost_nxt = 1'b0;

        if (!playGame) begin
            w_state_nxt     = S_IDLE;
            w_lives_nxt     = 3'd0;
            w_blink_cnt_nxt = 4'd0;
        end else if (startGame) begin
            w_state_nxt     = S_ALIVE;
            w_lives_nxt     = 3'(LIVES);
            w_blink_cnt_nxt = 4'd0;
        end else begin
            case (r_state)
                S_ALIVE: begin
                    if (playerHit) begin
                        w_life_lost_nxt = 1'b1;
                        if (r_lives <= 3'd1) begin
                            w_state_nxt = S_OVER;
                            w_lives_nxt = 3'd0;
                        end else begin
                            w_state_nxt     = S_BLINK;
                            w_lives_nxt     = r_lives - 3'd1;
                            w_blink_cnt_nxt = 4'(BLINK_TICKS);
                        end
                    end
                end
                S_BLINK: begin
                    // Hits are ignored here, including one coinciding with
                    // the final tick edge.
                    if (w_tick_edge && (r_blink_cnt != 4'd0)) begin
                        w_blink_cnt_nxt = r_blink_cnt - 4'd1;
                        if (r_blink_cnt == 4'd1) begin
                            w_state_nxt = S_ALIVE;
                        end
                    end
                end
                S_IDLE, S_OVER: begin
                end
                default: begin
                    w_state_nxt = S_IDLE;
                end
            endcase
        end
    end

    // Outputs decode registered state only.
    always_comb begin
        visible      = 1'b0;
        invulnerable = 1'b1;
        gameOver     = 1'b0;
        case (r_state)
            S_ALIVE: begin
                visible      = 1'b1;
                invulnerable = 1'b0;
            end
            S_BLINK: begin
                visible = ~r_blink_cnt[0];
            end
            S_OVER: begin
                gameOver = 1'b1;
            end
            default: begin
            end
        endcase
    end

    assign lives    = r_lives;
    assign lifeLost = r_life_lost;

endmodule

// File: tb/tb_player_life_ctrl.sv
// ---------------------------------------------------------------------------
// tb_player_life_ctrl
// Directed bench for player_life_ctrl with LIVES=3, BLINK_TICKS=8.
// Inputs change 1 time unit after the rising edge; outputs are checked there.
// ---------------------------------------------------------------------------
module tb_player_life_ctrl;

    logic       clk = 1'b0;
    logic       resetN;
    logic       playGame;
    logic       startGame;
    logic       tick;
    logic       playerHit;
    logic       visible;
    logic       invulnerable;
    logic [2:0] lives;
    logic       lifeLost;
    logic       gameOver;

    int n_tests = 0;
    int n_fail  = 0;
    int ll_cnt  = 0;

    player_life_ctrl #(.LIVES(3), .BLINK_TICKS(8)) dut (
        .clk          (clk),
        .resetN       (resetN),
        .playGame     (playGame),
        .startGame    (startGame),
        .tick         (tick),
        .playerHit    (playerHit),
        .visible      (visible),
        .invulnerable (invulnerable),
        .lives        (lives),
        .lifeLost     (lifeLost),
        .gameOver     (gameOver)
    );

    always #5 clk = ~clk;

    // lifeLost pulses counted mid-cycle.
    always @(negedge clk) begin
        if (lifeLost === 1'b1) ll_cnt = ll_cnt + 1;
    end

    task automatic check(input string tag, input int obs, input int exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic pulse_start();
        startGame = 1'b1;
        cyc(1);
        startGame = 1'b0;
    endtask

    task automatic pulse_hit();
        playerHit = 1'b1;
        cyc(1);
        playerHit = 1'b0;
    endtask

    task automatic pulse_tick();
        tick = 1'b1;
        cyc(1);
        tick = 1'b0;
        cyc(1);
    endtask

    task automatic blink_window();
        repeat (8) pulse_tick();
    endtask

    initial begin
        int base;
        int toggles;
        int prev_vis;
        int edges;

        resetN    = 1'b0;
        playGame  = 1'b1;
        startGame = 1'b0;
        tick      = 1'b0;
        playerHit = 1'b0;

        // Reset and idle
        #12;
        check("rst_visible", visible, 0);
        check("rst_lives", lives, 0);
        check("rst_gameover", gameOver, 0);
        check("rst_invuln", invulnerable, 1);
        check("rst_lifelost", lifeLost, 0);
        @(posedge clk);
        #1;
        resetN = 1'b1;
        cyc(100);
        check("idle_visible", visible, 0);
        check("idle_lives", lives, 0);
        check("idle_invuln", invulnerable, 1);

        // Start and a single hit
        pulse_start();
        check("start_lives", lives, 3);
        check("start_visible", visible, 1);
        check("start_invuln", invulnerable, 0);
        base = ll_cnt;
        pulse_hit();
        check("hit_lifelost", lifeLost, 1);
        check("hit_lives", lives, 2);
        check("hit_invuln", invulnerable, 1);
        check("hit_visible", visible, 1);
        cyc(1);
        check("hit_lifelost_drop", lifeLost, 0);
        toggles  = 0;
        prev_vis = visible;
        for (int i = 1; i <= 8; i++) begin
            tick = 1'b1;
            cyc(1);
            check($sformatf("blink_vis_%0d", i), visible, ((8 - i) % 2 == 0) ? 1 : 0);
            check($sformatf("blink_inv_%0d", i), invulnerable, (i < 8) ? 1 : 0);
            if (visible !== prev_vis[0]) toggles++;
            prev_vis = visible;
            tick = 1'b0;
            cyc(1);
        end
        check("blink_toggles", toggles, 8);
        check("blink_lives", lives, 2);
        check("single_hit_pulses", ll_cnt - base, 1);

        // Hits masked during BLINK, including at the final tick edge
        pulse_start();
        base      = ll_cnt;
        playerHit = 1'b1;
        cyc(1);
        check("mask_first_lives", lives, 2);
        cyc(1);
        for (int i = 1; i <= 7; i++) pulse_tick();
        check("mask_mid_lives", lives, 2);
        check("mask_mid_pulses", ll_cnt - base, 1);
        tick = 1'b1;
        cyc(1);
        check("mask_end_lives", lives, 2);
        check("mask_end_invuln", invulnerable, 0);
        tick = 1'b0;
        cyc(1);
        check("mask_rehit_lives", lives, 1);
        check("mask_rehit_pulse", lifeLost, 1);
        playerHit = 1'b0;
        cyc(1);
        check("mask_total_pulses", ll_cnt - base, 2);

        // Game over after three hits
        pulse_start();
        check("go_start_lives", lives, 3);
        pulse_hit();
        check("go_hit1_lives", lives, 2);
        blink_window();
        pulse_hit();
        check("go_hit2_lives", lives, 1);
        blink_window();
        pulse_hit();
        check("go_hit3_lives", lives, 0);
        check("go_gameover", gameOver, 1);
        check("go_visible", visible, 0);
        check("go_lifelost", lifeLost, 1);
        cyc(3);
        check("go_hold", gameOver, 1);
        pulse_start();
        check("go_restart_lives", lives, 3);
        check("go_restart_over", gameOver, 0);

        // Hit and start together in ALIVE: restart wins
        base      = ll_cnt;
        playerHit = 1'b1;
        startGame = 1'b1;
        cyc(1);
        playerHit = 1'b0;
        startGame = 1'b0;
        check("hs_lives", lives, 3);
        check("hs_lifelost", lifeLost, 0);
        check("hs_invuln", invulnerable, 0);

        // Long tick level counts once
        pulse_hit();
        check("long_vis0", visible, 1);
        tick = 1'b1;
        cyc(50);
        check("long_vis1", visible, 0);
        tick = 1'b0;
        cyc(1);
        edges = 0;
        while (invulnerable === 1'b1 && edges < 20) begin
            pulse_tick();
            edges++;
        end
        check("long_remaining_edges", edges, 7);

        // playGame override mid-BLINK
        pulse_hit();
        pulse_tick();
        check("ovr_pre_lives", lives, 1);
        playGame = 1'b0;
        cyc(1);
        check("ovr_lives", lives, 0);
        check("ovr_visible", visible, 0);
        check("ovr_invuln", invulnerable, 1);
        startGame = 1'b1;
        cyc(1);
        startGame = 1'b0;
        check("ovr_start_blocked", lives, 0);
        playGame = 1'b1;
        cyc(5);
        check("ovr_stay_idle", lives, 0);

        // Asynchronous reset mid-BLINK
        pulse_start();
        pulse_hit();
        check("ar_pre_lifelost", lifeLost, 1);
        #2;
        resetN = 1'b0;
        #1;
        check("ar_lives", lives, 0);
        check("ar_lifelost", lifeLost, 0);
        check("ar_visible", visible, 0);
        check("ar_invuln", invulnerable, 1);
        #1;
        resetN = 1'b1;
        cyc(3);
        check("ar_stay_idle", lives, 0);
        check("ar_idle_invuln", invulnerable, 1);
        pulse_start();
        check("ar_restart", lives, 3);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/player_life_ctrl.md
# player_life_ctrl

Sequencing controller for the player sprite: counts remaining lives, runs the post-hit invulnerability/blink window, and declares game over. It sits between the collision logic (playerHit) and the player bitmap/drawing path. It tells the bitmap when to be visible, tells the collision logic when hits are masked, and tells the top level when the game has ended.

## Interface
Parameters:
- LIVES, 3: lives loaded at game start; legal range 1..7.
- BLINK_TICKS, 8: tick edges spent in the blink window after a non-fatal hit; legal range 2..15.

Ports:
- clk  in  1  system clock.
- resetN  in  1  reset, asynchronous, active-low.
- playGame  in  1  level; low forces IDLE synchronously and overrides all other inputs.
- startGame  in  1  single-cycle pulse; starts or restarts a game.
- tick  in  1  slow timebase level, e.g. a one_sec_counter output; internally rising-edge detected.
- playerHit  in  1  collision report; sampled every cycle.
- visible  out  1  player sprite may be drawn; bitmap drawingRequest is ANDed with this.
- invulnerable  out  1  hits are currently masked.
- lives  out  3  remaining lives.
- lifeLost  out  1  one-cycle pulse per accepted hit.
- gameOver  out  1  level, high in OVER.

## Operation
- States: IDLE, ALIVE, BLINK, OVER. Encoding is free.
- Tick edge detection:
  - tickEdge = tick & !tickQ, where tickQ is a 1-cycle registered copy of tick.
  - A tick held high for many cycles counts once.
- IDLE:
  - visible=0, invulnerable=1, lives=0, gameOver=0.
  - startGame moves to ALIVE and loads lives=LIVES.
- ALIVE:
  - visible=1, invulnerable=0.
  - A hit is accepted when playerHit=1. On acceptance: lives-1 and lifeLost=1 for one cycle.
  - If lives was 1 before the hit, go to OVER with lives=0.
  - Otherwise go to BLINK and load blinkCnt=BLINK_TICKS.
- BLINK:
  - invulnerable=1; playerHit is ignored and produces no lifeLost.
  - visible = blinkCnt[0]==0, so the sprite toggles on each tick edge and is visible at entry when BLINK_TICKS is even.
  - Each tickEdge decrements blinkCnt.
  - The tickEdge that decrements blinkCnt from 1 to 0 also moves the block to ALIVE.
- OVER:
  - gameOver=1, visible=0, invulnerable=1, lives=0.
  - startGame moves to ALIVE and reloads lives=LIVES.
- Any state, startGame: restarts to ALIVE with lives=LIVES and blinkCnt=0. This includes startGame during ALIVE or BLINK.
- playGame=0: on the next clock, go to IDLE and clear lives, blinkCnt, lifeLost and tickQ.
- Width rules:
  - lives is 3-bit unsigned and never decrements below 0.
  - blinkCnt is 4-bit unsigned with no wrap; it is decremented only while nonzero.

## Timing
- Reset values (resetN low, asynchronous):
  - state=IDLE, lives=0, blinkCnt=0, tickQ=0.
  - visible=0, invulnerable=1, lifeLost=0, gameOver=0.
- All outputs are registered or decoded from registered state only; there is no combinational input-to-output path.
- Latencies:
  - Hit accepted at edge N: lifeLost=1, lives updated and new state visible in the cycle after edge N. lifeLost drops at edge N+1.
  - tickEdge detected at edge N (tick high, tickQ low): blinkCnt and visible update in the cycle after edge N.
  - startGame at edge N: ALIVE and lives=LIVES in the cycle after edge N.
- Priority, highest first: playGame=0, startGame, accepted playerHit, tickEdge.
- Simultaneous events:
  - playerHit and startGame in the same cycle in ALIVE: the restart wins; lives=LIVES and there is no lifeLost.
  - playerHit and the final tickEdge in the same cycle in BLINK: the block returns to ALIVE and the hit is ignored. The next cycle's playerHit is accepted normally.
  - playerHit held high across the BLINK-to-ALIVE transition: accepted once in the first ALIVE cycle, which starts a new BLINK.
- Reset asserted mid-BLINK: immediate return to reset values. After release, the block stays in IDLE until startGame.

## Test plan
- Reset then idle: with resetN low, check visible=0, lives=0, gameOver=0, invulnerable=1. After release, with no startGame for 100 cycles, the state is unchanged.
- Start and single hit (LIVES=3, BLINK_TICKS=8):
  - Pulse startGame; lives=3 and visible=1.
  - Pulse playerHit; one lifeLost pulse, lives=2, invulnerable=1.
  - visible toggles over exactly 8 tick edges.
  - ALIVE is reached after the 8th edge with visible=1 and invulnerable=0.
- Hits masked in BLINK: hold playerHit high for the whole blink window. Expect lives=2 and exactly one lifeLost during BLINK, then one more lifeLost (lives=1) on the first ALIVE cycle.
- Game over: three hits, each separated by a completed blink window. Expect lives 3→2→1→0 and gameOver=1 on the cycle after the third hit, with visible=0. A later startGame gives lives=3 and gameOver=0.
- Long tick level: hold tick high for 50 cycles during BLINK. Expect blinkCnt to decrement by exactly 1.
- Override and async reset:
  - Drop playGame mid-BLINK: IDLE on the next cycle with lives=0.
  - Separately, assert resetN low between clock edges mid-BLINK: outputs take reset values before the next edge.
